// File: rtl/cache_ctrl.sv
`timescale 1ns/1ps
// cache_ctrl: direct-mapped, write-through, no-write-allocate byte cache sitting between a
// CPU requester and a byte-addressed 1 KiB memory with 32-bit read words.
//
// Request flow: Idle -> Read (registered line read) -> Lookup, then one of
//   read hit  -> Respond
//   read miss -> Refill   -> Respond
//   write     -> WriteMem -> Respond
// Respond drives the one-cycle o_cpu_ready pulse. The memory wait is bounded by TIMEOUT_CYCLES.
// Only a completed wait returns normally. If the wait times out, the response carries
// o_cpu_err instead.
//
// Optional feature: define CACHE_STATS_EN to build saturating 16-bit hit/miss counters;
// without it o_hit_count/o_miss_count are tied to zero.

module cache_ctrl #(
    parameter int unsigned NUM_LINES      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [9:0]  i_cpu_addr,
    input  logic [7:0]  i_cpu_wdata,
    output logic [7:0]  o_cpu_rdata,
    output logic        o_cpu_ready,
    output logic        o_cpu_err,
    output logic        o_cpu_busy,
    output logic        o_mem_read_req,
    output logic        o_mem_write_req,
    output logic [9:0]  o_mem_addr,
    output logic [7:0]  o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_rr,
    input  logic        i_mem_wr,
    output logic [15:0] o_hit_count,
    output logic [15:0] o_miss_count
);

    localparam int unsigned INDEX_W  = $clog2(NUM_LINES);
    localparam int unsigned TAG_W    = 8 - INDEX_W;
    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StLookup,
        StRefill,
        StWriteMem,
        StRespond
    } state_t;

    // Selects byte 'off' from a big-endian word: offset 0 lives in [31:24].
    function automatic logic [7:0] f_sel_byte(input logic [31:0] word, input logic [1:0] off);
        logic [7:0] b;
        unique case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

    state_t               r_state;
    logic [9:0]           r_addr;
    logic                 r_we;
    logic [7:0]           r_wdata;
    logic [7:0]           r_tmo_cnt;
    logic                 r_wr_hit;

    // Line array; data and tag carry no reset because r_valid qualifies them.
    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [31:0]          r_data [NUM_LINES];

    // Registered copy of the indexed line, taken in StRead.
    logic                 r_rd_valid;
    logic [TAG_W-1:0]     r_rd_tag;
    logic [31:0]          r_rd_data;

    logic [7:0]           r_cpu_rdata;
    logic                 r_cpu_ready;
    logic                 r_cpu_err;
    logic                 r_cpu_busy;
    logic                 r_mem_read_req;
    logic                 r_mem_write_req;
    logic [9:0]           r_mem_addr;
    logic [7:0]           r_mem_wdata;

    logic [INDEX_W-1:0]   w_index;
    logic [TAG_W-1:0]     w_tag;
    logic [1:0]           w_offset;
    logic                 w_hit;
    logic                 w_tmo;
    logic [31:0]          w_merged;
    logic                 w_line_we;
    logic [31:0]          w_line_wdata;

    assign w_offset = r_addr[1:0];
    assign w_index  = r_addr[2 +: INDEX_W];
    assign w_tag    = r_addr[9 -: TAG_W];
    assign w_hit    = r_rd_valid && (r_rd_tag == w_tag);
    assign w_tmo    = (r_tmo_cnt == TMO_LAST);

    // Cached line with the pending write byte merged in, used for write hits.
    always_comb begin
        w_merged = r_rd_data;
        unique case (w_offset)
            2'd0:    w_merged[31:24] = r_wdata;
            2'd1:    w_merged[23:16] = r_wdata;
            2'd2:    w_merged[15:8]  = r_wdata;
            default: w_merged[7:0]   = r_wdata;
        endcase
    end

    // Line write port: write hit in Lookup, or refill completing in Refill.
    always_comb begin
        w_line_we    = 1'b0;
        w_line_wdata = w_merged;
        if (r_state == StLookup && r_we && w_hit) begin
            w_line_we = 1'b1;
        end else if (r_state == StRefill && i_mem_rr) begin
            w_line_we    = 1'b1;
            w_line_wdata = i_mem_rdata;
        end
    end

    // Line data/tag storage update.
    always_ff @(posedge i_clk) begin
        if (w_line_we) begin
            r_data[w_index] <= w_line_wdata;
            r_tag[w_index]  <= w_tag;
        end
    end

    // Main controller FSM with registered CPU and memory-side outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= StIdle;
            r_addr          <= '0;
            r_we            <= 1'b0;
            r_wdata         <= '0;
            r_tmo_cnt       <= '0;
            r_wr_hit        <= 1'b0;
            r_valid         <= '0;
            r_rd_valid      <= 1'b0;
            r_rd_tag        <= '0;
            r_rd_data       <= '0;
            r_cpu_rdata     <= '0;
            r_cpu_ready     <= 1'b0;
            r_cpu_err       <= 1'b0;
            r_cpu_busy      <= 1'b0;
            r_mem_read_req  <= 1'b0;
            r_mem_write_req <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_cpu_req) begin
                        r_addr     <= i_cpu_addr;
                        r_we       <= i_cpu_we;
                        r_wdata    <= i_cpu_wdata;
                        r_cpu_busy <= 1'b1;
                        r_state    <= StRead;
                    end
                end
                StRead: begin
                    r_rd_valid <= r_valid[w_index];
                    r_rd_tag   <= r_tag[w_index];
                    r_rd_data  <= r_data[w_index];
                    r_state    <= StLookup;
                end
                StLookup: begin
                    r_wr_hit <= r_we && w_hit;
                    if (r_we) begin
                        // Write-through for hits and misses; a miss never allocates.
                        r_mem_write_req <= 1'b1;
                        r_mem_addr      <= r_addr;
                        r_mem_wdata     <= r_wdata;
                        r_tmo_cnt       <= '0;
                        r_state         <= StWriteMem;
                    end else if (w_hit) begin
                        r_cpu_ready <= 1'b1;
                        r_cpu_err   <= 1'b0;
                        r_cpu_rdata <= f_sel_byte(r_rd_data, w_offset);
                        r_state     <= StRespond;
                    end else begin
                        r_mem_read_req <= 1'b1;
                        r_mem_addr     <= {r_addr[9:2], 2'b00};
                        r_tmo_cnt      <= '0;
                        r_state        <= StRefill;
                    end
                end
                StRefill: begin
                    if (i_mem_rr) begin
                        r_mem_read_req   <= 1'b0;
                        r_mem_addr       <= '0;
                        r_valid[w_index] <= 1'b1;
                        r_cpu_ready      <= 1'b1;
                        r_cpu_err        <= 1'b0;
                        r_cpu_rdata      <= f_sel_byte(i_mem_rdata, w_offset);
                        r_state          <= StRespond;
                    end else if (w_tmo) begin
                        // Memory never answered: abandon the refill, line stays as it was.
                        r_mem_read_req <= 1'b0;
                        r_mem_addr     <= '0;
                        r_cpu_ready    <= 1'b1;
                        r_cpu_err      <= 1'b1;
                        r_cpu_rdata    <= '0;
                        r_state        <= StRespond;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    end
                end
                StWriteMem: begin
                    if (i_mem_wr || w_tmo) begin
                        r_mem_write_req <= 1'b0;
                        r_mem_addr      <= '0;
                        r_mem_wdata     <= '0;
                        r_cpu_ready     <= 1'b1;
                        r_cpu_err       <= !i_mem_wr;
                        r_cpu_rdata     <= '0;
                        r_state         <= StRespond;
                        // The cached byte no longer matches memory after a failed write.
                        if (!i_mem_wr && r_wr_hit) begin
                            r_valid[w_index] <= 1'b0;
                        end
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    end
                end
                StRespond: begin
                    r_cpu_ready <= 1'b0;
                    r_cpu_err   <= 1'b0;
                    r_cpu_rdata <= '0;
                    r_cpu_busy  <= 1'b0;
                    r_state     <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_cpu_rdata     = r_cpu_rdata;
    assign o_cpu_ready     = r_cpu_ready;
    assign o_cpu_err       = r_cpu_err;
    assign o_cpu_busy      = r_cpu_busy;
    assign o_mem_read_req  = r_mem_read_req;
    assign o_mem_write_req = r_mem_write_req;
    assign o_mem_addr      = r_mem_addr;
    assign o_mem_wdata     = r_mem_wdata;

`ifdef CACHE_STATS_EN
    logic [15:0] r_hit_count;
    logic [15:0] r_miss_count;

    // Saturating hit/miss counters, stepped once per lookup.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (r_state == StLookup) begin
            if (w_hit) begin
                if (r_hit_count != 16'hFFFF) begin
                    r_hit_count <= r_hit_count + 16'd1;
                end
            end else if (r_miss_count != 16'hFFFF) begin
                r_miss_count <= r_miss_count + 16'd1;
            end
        end
    end

    assign o_hit_count  = r_hit_count;
    assign o_miss_count = r_miss_count;
`else
    assign o_hit_count  = '0;
    assign o_miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
`timescale 1ns/1ps
// tb_cache_ctrl: directed plus randomized accesses checked against a line-level cache model
// and a byte-array memory reference.

module tb_cache_ctrl;

    localparam int NL    = 8;
    localparam int TMO   = 15;
    localparam int BOUND = TMO + 12;

    logic        clk;
    logic        rst_n;
    logic        mem_rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [9:0]  cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready;
    logic        cpu_err;
    logic        cpu_busy;
    logic        mem_read_req;
    logic        mem_write_req;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_rr;
    logic        mem_wr;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    // Bench memory and its responder
    logic [7:0]  mem [1024];
    bit          mem_en;
    logic [9:0]  mem_base;

    // Reference model
    logic [7:0]  ref_mem [1024];
    bit          ref_v [NL];
    int          ref_t [NL];
    logic [7:0]  ref_d [NL][4];
    int          exp_hits;
    int          exp_misses;

    int          checks;
    int          errors;
    logic [7:0]  last_rd;
    int          last_lat;

    cache_ctrl #(
        .NUM_LINES      (NL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_cpu_req       (cpu_req),
        .i_cpu_we        (cpu_we),
        .i_cpu_addr      (cpu_addr),
        .i_cpu_wdata     (cpu_wdata),
        .o_cpu_rdata     (cpu_rdata),
        .o_cpu_ready     (cpu_ready),
        .o_cpu_err       (cpu_err),
        .o_cpu_busy      (cpu_busy),
        .o_mem_read_req  (mem_read_req),
        .o_mem_write_req (mem_write_req),
        .o_mem_addr      (mem_addr),
        .o_mem_wdata     (mem_wdata),
        .i_mem_rdata     (mem_rdata),
        .i_mem_rr        (mem_rr),
        .i_mem_wr        (mem_wr),
        .o_hit_count     (hit_count),
        .o_miss_count    (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            4:       return 8'h11;
            5:       return 8'h22;
            6:       return 8'h33;
            7:       return 8'h44;
            default: return 8'((i * 37 + 5) % 256);
        endcase
    endfunction

    assign mem_base  = {mem_addr[9:2], 2'b00};
    assign mem_rdata = {mem[mem_base], mem[mem_base + 10'd1],
                        mem[mem_base + 10'd2], mem[mem_base + 10'd3]};

    // Memory answers one cycle after it first sees a request, when enabled.
    always @(posedge clk or negedge mem_rst_n) begin
        if (!mem_rst_n) begin
            mem_rr <= 1'b0;
            mem_wr <= 1'b0;
            for (int i = 0; i < 1024; i++) mem[i] <= init_byte(i);
        end else begin
            mem_rr <= mem_en && mem_read_req && !mem_rr;
            mem_wr <= mem_en && mem_write_req && !mem_wr;
            if (mem_en && mem_write_req && !mem_wr) mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_stats();
`ifdef CACHE_STATS_EN
        check("hit_count", 32'(hit_count), 32'(exp_hits));
        check("miss_count", 32'(miss_count), 32'(exp_misses));
`else
        check("hit_count_tied", 32'(hit_count), 32'h0);
        check("miss_count_tied", 32'(miss_count), 32'h0);
`endif
    endtask

    // One CPU access; expectations come from the model before the access is issued.
    task automatic access(input logic we, input logic [9:0] addr, input logic [7:0] wd,
                          input bit ok);
        int idx, tg, base, off, lat, rc, wc, exp_lat, exp_rc, exp_wc;
        bit hit, got, both, abad, busy_low, exp_err;
        logic [7:0] rd, exp_rd;
        logic [9:0] exp_maddr;
        logic er;

        base = int'(addr) - int'(addr) % 4;
        off  = int'(addr) % 4;
        idx  = (int'(addr) / 4) % NL;
        tg   = int'(addr) / (4 * NL);
        hit  = ref_v[idx] && (ref_t[idx] == tg);
        exp_rc = 0;
        exp_wc = 0;
        exp_rd = 8'h00;
        exp_err = 1'b0;
        if (!we) begin
            exp_maddr = 10'(base);
            if (hit) begin
                exp_lat = 2;
                exp_rd  = ref_d[idx][off];
            end else if (ok) begin
                exp_lat = 4;
                exp_rc  = 2;
                exp_rd  = ref_mem[addr];
                for (int i = 0; i < 4; i++) ref_d[idx][i] = ref_mem[base + i];
                ref_v[idx] = 1'b1;
                ref_t[idx] = tg;
            end else begin
                exp_lat = 2 + TMO;
                exp_rc  = TMO;
                exp_err = 1'b1;
            end
        end else begin
            exp_maddr = addr;
            if (ok) begin
                exp_lat = 4;
                exp_wc  = 2;
                ref_mem[addr] = wd;
                if (hit) ref_d[idx][off] = wd;
            end else begin
                exp_lat = 2 + TMO;
                exp_wc  = TMO;
                exp_err = 1'b1;
                if (hit) ref_v[idx] = 1'b0;
            end
        end
        if (hit) exp_hits++;
        else exp_misses++;

        mem_en = ok;
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        check("busy_at_accept", 32'(cpu_busy), 32'h1);

        lat = 0; rc = 0; wc = 0; got = 0; both = 0; abad = 0; busy_low = 0;
        rd = 8'h00; er = 1'b0;
        while (!got && lat < BOUND) begin
            @(posedge clk);
            #1;
            lat++;
            if (!cpu_busy) busy_low = 1'b1;
            if (mem_read_req && mem_write_req) both = 1'b1;
            if (cpu_ready) begin
                got = 1'b1;
                rd  = cpu_rdata;
                er  = cpu_err;
                if (mem_read_req || mem_write_req) abad = 1'b1;
            end else begin
                if (mem_read_req) begin
                    rc++;
                    if (mem_addr !== exp_maddr) abad = 1'b1;
                end
                if (mem_write_req) begin
                    wc++;
                    if (mem_addr !== exp_maddr || mem_wdata !== wd) abad = 1'b1;
                end
                if (!mem_read_req && !mem_write_req && (mem_addr !== 10'h0 || mem_wdata !== 8'h0))
                    abad = 1'b1;
            end
        end
        check("ready_seen", 32'(got), 32'h1);
        check("latency", 32'(lat), 32'(exp_lat));
        check("rdata", 32'(rd), 32'(exp_rd));
        check("err", 32'(er), 32'(exp_err));
        check("read_req_cycles", 32'(rc), 32'(exp_rc));
        check("write_req_cycles", 32'(wc), 32'(exp_wc));
        check("mem_bus_values", 32'({both, abad}), 32'h0);
        check("busy_held", 32'(busy_low), 32'h0);

        @(posedge clk);
        #1;
        check("ready_pulse_one", 32'(cpu_ready), 32'h0);
        check("busy_falls", 32'(cpu_busy), 32'h0);
        if (we) check("mem_content", 32'(mem[addr]), 32'(ref_mem[addr]));
        check_stats();
        mem_en   = 1'b0;
        last_rd  = rd;
        last_lat = lat;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_ready;
        logic [9:0] a;

        checks = 0; errors = 0; exp_hits = 0; exp_misses = 0;
        rst_n = 1'b0; mem_rst_n = 1'b0; mem_en = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_byte(i);
        for (int i = 0; i < NL; i++) begin
            ref_v[i] = 1'b0;
            ref_t[i] = 0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs_a", 32'({cpu_ready, cpu_err, cpu_busy, mem_read_req, mem_write_req}),
              32'h0);
        check("rst_rdata", 32'(cpu_rdata), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        check("rst_hit_count", 32'(hit_count), 32'h0);
        check("rst_miss_count", 32'(miss_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rst_n = 1'b1;

        // Cold read miss, then hit in the same line
        access(1'b0, 10'h005, 8'h00, 1'b1);
        check("first_read_value", 32'(last_rd), 32'h22);
        access(1'b0, 10'h007, 8'h00, 1'b1);
        check("hit_read_value", 32'(last_rd), 32'h44);
        check("hit_latency", 32'(last_lat), 32'd2);

        // Write hit then read back from the cache
        access(1'b1, 10'h006, 8'hAB, 1'b1);
        access(1'b0, 10'h006, 8'h00, 1'b1);
        check("write_readback", 32'(last_rd), 32'hAB);

        // Conflict in index 1 replaces the line
        access(1'b0, 10'h025, 8'h00, 1'b1);
        access(1'b0, 10'h005, 8'h00, 1'b1);
        check("conflict_remiss", 32'(last_lat), 32'd4);

        // Read timeout leaves the line unfilled
        access(1'b0, 10'h040, 8'h00, 1'b0);
        access(1'b0, 10'h040, 8'h00, 1'b1);
        check("after_read_tmo_miss", 32'(last_lat), 32'd4);

        // Write-hit timeout invalidates the line; memory keeps its old byte
        access(1'b1, 10'h005, 8'h5A, 1'b0);
        access(1'b0, 10'h005, 8'h00, 1'b1);
        check("after_write_tmo", 32'(last_rd), 32'h22);
        check("after_write_tmo_miss", 32'(last_lat), 32'd4);

        // Reset asserted mid-refill
        access(1'b0, 10'h100, 8'h00, 1'b1);
        mem_en = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h204;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("refill_pending", 32'(mem_read_req), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_drops_read_req", 32'(mem_read_req), 32'h0);
        check("rst_drops_busy", 32'(cpu_busy), 32'h0);
        check("rst_mem_addr_mid", 32'(mem_addr), 32'h0);
        saw_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (cpu_ready) saw_ready = 1'b1;
        end
        check("no_ready_after_rst", 32'(saw_ready), 32'h0);
        for (int i = 0; i < NL; i++) ref_v[i] = 1'b0;
        exp_hits = 0;
        exp_misses = 0;
        access(1'b0, 10'h100, 8'h00, 1'b1);
        check("post_rst_miss", 32'(last_lat), 32'd4);

        // Randomized traffic against the model
        for (int n = 0; n < 40; n++) begin
            a = 10'($urandom_range(0, 127));
            if ($urandom_range(0, 7) == 0) a = 10'($urandom_range(0, 1023));
            access(($urandom_range(0, 2) == 0), a, 8'($urandom_range(0, 255)),
                   ($urandom_range(0, 9) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
